dtw_min_tracker: RTL and testbench

Downstream stage of the DTW systolic array. It consumes the accumulated-cost stream (DTWc) leaving the last processing element, one word per reference sample. It tracks the minimum cost and the reference index where that minimum occurs, which is the subsequence-DTW match end point. At the end of each query it presents the result on a valid/ready handshake to the host-side result logic.

---
 rtl/dtw_pkg.sv | 15 +
 rtl/dtw_min_update.sv | 39 +++
 rtl/dtw_min_tracker.sv | 132 +++++++++++++
 tb/tb_dtw_min_tracker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared types and constants for the DTW minimum tracker
package dtw_pkg;

    localparam int DTW_WIDTH = 16;
    localparam int DTW_IDXW  = 20;

    localparam logic [DTW_WIDTH-1:0] COST_MAX = {DTW_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dtw_state_t;

endpackage

// File: rtl/dtw_min_update.sv
// rtl/dtw_min_update.sv - combinational min/position/runner-up select (DTW_RUNNER_UP_EN)
module dtw_min_update #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 20
) (
    input  logic [WIDTH-1:0] cost,
    input  logic [IDXW-1:0]  cnt,
    input  logic [WIDTH-1:0] min,
    input  logic [IDXW-1:0]  pos,
`ifdef DTW_RUNNER_UP_EN
    input  logic [WIDTH-1:0] second,
    output logic [WIDTH-1:0] next_second,
`endif
    output logic [WIDTH-1:0] next_min,
    output logic [IDXW-1:0]  next_pos
);

    // Strict compare keeps the earliest index on ties and never lets an all-ones cost move pos.
    always_comb begin
        next_min = min;
        next_pos = pos;
        if (cost < min) begin
            next_min = cost;
            next_pos = cnt;
        end
    end

`ifdef DTW_RUNNER_UP_EN
    always_comb begin
        next_second = second;
        if (cost < min) begin
            next_second = min;
        end else if (cost < second) begin
            next_second = cost;
        end
    end
`endif

endmodule

// File: rtl/dtw_min_tracker.sv
// rtl/dtw_min_tracker.sv - DTW cost-stream minimum tracker; optional runner-up via DTW_RUNNER_UP_EN
module dtw_min_tracker
    import dtw_pkg::*;
#(
    parameter int WIDTH = DTW_WIDTH,
    parameter int IDXW  = DTW_IDXW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDXW-1:0]  ref_len,
    input  logic             cost_valid,
    input  logic [WIDTH-1:0] cost,
    output logic             cost_ready,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_min,
    output logic [IDXW-1:0]  res_pos
`ifdef DTW_RUNNER_UP_EN
    ,
    output logic [WIDTH-1:0] res_second
`endif
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    dtw_state_t       state;
    logic [IDXW-1:0]  len_q;
    logic [IDXW-1:0]  cnt;
    logic [WIDTH-1:0] min_q;
    logic [IDXW-1:0]  pos_q;
    logic [WIDTH-1:0] nxt_min;
    logic [IDXW-1:0]  nxt_pos;
    logic             last_beat;
`ifdef DTW_RUNNER_UP_EN
    logic [WIDTH-1:0] second_q;
    logic [WIDTH-1:0] nxt_second;
`endif

    dtw_min_update #(
        .WIDTH(WIDTH),
        .IDXW (IDXW)
    ) u_update (
        .cost       (cost),
        .cnt        (cnt),
        .min        (min_q),
        .pos        (pos_q),
`ifdef DTW_RUNNER_UP_EN
        .second     (second_q),
        .next_second(nxt_second),
`endif
        .next_min   (nxt_min),
        .next_pos   (nxt_pos)
    );

    assign last_beat = (cnt == len_q - 1'b1);

    // Handshake flags are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt        <= '0;
            min_q      <= '0;
            pos_q      <= '0;
            cost_ready <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
`ifdef DTW_RUNNER_UP_EN
            second_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= ref_len;
                        cnt      <= '0;
                        min_q    <= ALL_ONES;
                        pos_q    <= '0;
`ifdef DTW_RUNNER_UP_EN
                        second_q <= ALL_ONES;
`endif
                        busy     <= 1'b1;
                        if (ref_len == '0) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end else begin
                            state      <= RUN;
                            cost_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cost_valid) begin
                        min_q    <= nxt_min;
                        pos_q    <= nxt_pos;
`ifdef DTW_RUNNER_UP_EN
                        second_q <= nxt_second;
`endif
                        cnt      <= cnt + 1'b1;
                        if (last_beat) begin
                            state      <= DONE;
                            cost_ready <= 1'b0;
                            res_valid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cost_ready <= 1'b0;
                    busy       <= 1'b0;
                    res_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign res_min = min_q;
    assign res_pos = pos_q;
`ifdef DTW_RUNNER_UP_EN
    assign res_second = second_q;
`endif

endmodule

// File: tb/tb_dtw_min_tracker.sv
// tb/tb_dtw_min_tracker.sv - directed-vector bench for dtw_min_tracker (DTW_RUNNER_UP_EN aware)
module tb_dtw_min_tracker;
    import dtw_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] ref_len;
    logic        cost_valid;
    logic [15:0] cost;
    logic        cost_ready;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_min;
    logic [19:0] res_pos;
`ifdef DTW_RUNNER_UP_EN
    logic [15:0] res_second;
`endif

    int total = 0;
    int bad   = 0;

    dtw_min_tracker #(
        .WIDTH(16),
        .IDXW (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_len   (ref_len),
        .cost_valid(cost_valid),
        .cost      (cost),
        .cost_ready(cost_ready),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_min   (res_min),
`ifdef DTW_RUNNER_UP_EN
        .res_second(res_second),
`endif
        .res_pos   (res_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [15:0] emin, input logic [19:0] epos,
                           input logic [15:0] esec);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_min"}, {16'd0, res_min}, {16'd0, emin});
        chk({tag, "_pos"}, {12'd0, res_pos}, {12'd0, epos});
`ifdef DTW_RUNNER_UP_EN
        chk({tag, "_second"}, {16'd0, res_second}, {16'd0, esec});
`else
        if (esec == 16'hDEAD) chk({tag, "_sec_unused"}, 32'd0, 32'd1);
`endif
    endtask

    task automatic start_q(input logic [19:0] len);
        start   = 1'b1;
        ref_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic beat(input logic [15:0] c, input int stall);
        cost_valid = 1'b0;
        repeat (stall) tick();
        chk("beat_ready", {31'd0, cost_ready}, 32'd1);
        cost_valid = 1'b1;
        cost       = c;
        tick();
        cost_valid = 1'b0;
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("rel_valid", {31'd0, res_valid}, 32'd0);
        chk("rel_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cready"}, {31'd0, cost_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_min"}, {16'd0, res_min}, 32'd0);
        chk({tag, "_pos"}, {12'd0, res_pos}, 32'd0);
`ifdef DTW_RUNNER_UP_EN
        chk({tag, "_second"}, {16'd0, res_second}, 32'd0);
`endif
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        ref_len    = '0;
        cost_valid = 1'b0;
        cost       = '0;
        res_ready  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk_reset_vals("reset");

        // basic back-to-back stream with a tie
        start_q(20'd5);
        chk("basic_cready", {31'd0, cost_ready}, 32'd1);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        beat(16'd9, 0);
        beat(16'd4, 0);
        beat(16'd7, 0);
        beat(16'd4, 0);
        chk("basic_not_yet", {31'd0, res_valid}, 32'd0);
        beat(16'd6, 0);
        chk_res("basic", 16'd4, 20'd1, 16'd4);
        chk("basic_cready_done", {31'd0, cost_ready}, 32'd0);
        release_res();

        // stalls between beats and backpressure on the result
        start_q(20'd4);
        beat(16'd10, 3);
        beat(16'd3, 3);
        beat(16'd8, 3);
        beat(16'd2, 3);
        for (int i = 0; i < 5; i++) begin
            chk_res("stall_hold", 16'd2, 20'd3, 16'd3);
            tick();
        end
        release_res();

        // zero length, stray beat in DONE
        start_q(20'd0);
        chk_res("zero", COST_MAX, 20'd0, COST_MAX);
        chk("zero_cready", {31'd0, cost_ready}, 32'd0);
        cost_valid = 1'b1;
        cost       = 16'd0;
        tick();
        cost_valid = 1'b0;
        chk_res("zero_stray", COST_MAX, 20'd0, COST_MAX);
        release_res();

        // ignored inputs: beats in IDLE, start in RUN and DONE
        cost_valid = 1'b1;
        cost       = 16'd0;
        repeat (2) tick();
        cost_valid = 1'b0;
        chk("ign_idle_busy", {31'd0, busy}, 32'd0);
        chk("ign_idle_cready", {31'd0, cost_ready}, 32'd0);
        start_q(20'd3);
        beat(16'd8, 0);
        start   = 1'b1;
        ref_len = 20'd1;
        beat(16'd5, 1);
        start   = 1'b0;
        chk("ign_run_valid", {31'd0, res_valid}, 32'd0);
        beat(16'd9, 0);
        start      = 1'b1;
        ref_len    = 20'd2;
        cost_valid = 1'b1;
        cost       = 16'd0;
        repeat (2) tick();
        cost_valid = 1'b0;
        chk_res("ign_done", 16'd5, 20'd1, 16'd8);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        chk("ign_start_on_release", {31'd0, busy}, 32'd0);
        tick();
        chk("ign_still_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of a query
        start_q(20'd6);
        beat(16'd3, 0);
        beat(16'd1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("midrst");
        tick();
        chk("midrst_no_valid", {31'd0, res_valid}, 32'd0);
        start_q(20'd2);
        beat(16'd5, 0);
        beat(16'd1, 0);
        chk_res("after_rst", 16'd1, 20'd1, 16'd5);
        release_res();

        // runner-up ordering and all-max costs
        start_q(20'd4);
        beat(16'd7, 0);
        beat(16'd3, 0);
        beat(16'd5, 0);
        beat(16'd1, 0);
        chk_res("runner", 16'd1, 20'd3, 16'd3);
        release_res();
        start_q(20'd3);
        beat(16'hFFFF, 0);
        beat(16'hFFFF, 2);
        beat(16'hFFFF, 0);
        chk_res("allmax", 16'hFFFF, 20'd0, 16'hFFFF);
        release_res();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
